// File: rtl/simd_mem_responder.sv
// simd_mem_responder: host-loadable instruction/data memories with a
// LOAD/RELEASE/RUN/HALT sequencer that holds the CPU in reset and serves
// its fetch and data ports on the falling clock edge.
module simd_mem_responder (
  input  logic        clk,
  input  logic        rst,
  input  logic        host_we,
  input  logic        host_re,
  input  logic        host_sel,
  input  logic [9:0]  host_addr,
  input  logic [17:0] host_wdata,
  input  logic        host_start,
  output logic [17:0] host_rdata,
  output logic        host_rvalid,
  output logic        host_err,
  output logic        cpu_rst,
  input  logic [9:0]  instruction_address,
  output logic [17:0] instruction_in,
  input  logic [9:0]  data_address,
  input  logic        data_R,
  input  logic        data_W,
  input  logic [15:0] data_out,
  output logic [15:0] data_in,
  input  logic        done,
  output logic        run_done,
  output logic [31:0] cycle_count,
  output logic [15:0] wr_count
);

  typedef enum logic [1:0] {LOAD, RELEASE, RUN, HALT} state_t;

  state_t      state;
  state_t      state_next;
  logic        rel_cnt;

  logic [17:0] imem [0:1023];
  logic [15:0] dmem [0:1023];

  logic        host_ok;
  logic        enter_release;
  logic        cpu_write;
  logic        cpu_read;

  logic        hw_pend;
  logic [9:0]  hw_addr;
  logic [15:0] hw_data;
  logic        cpu_wr;

  assign host_ok       = (state == LOAD) || (state == HALT);
  assign enter_release = (state_next == RELEASE) && (state != RELEASE);
  assign cpu_write     = !rst && (state == RUN) && data_R && data_W;
  assign cpu_read      = (state == RUN) && data_R && !data_W;

  // State register and the two-cycle RELEASE dwell counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= LOAD;
      rel_cnt <= 1'b0;
    end else begin
      state   <= state_next;
      rel_cnt <= (state == RELEASE) ? 1'b1 : 1'b0;
    end
  end

  // Next-state decode plus the state-derived CPU control outputs.
  always_comb begin
    state_next = state;
    cpu_rst    = 1'b1;
    run_done   = 1'b0;
    case (state)
      LOAD:    if (host_start) state_next = RELEASE;
      RELEASE: if (rel_cnt)    state_next = RUN;
      RUN: begin
        cpu_rst = 1'b0;
        if (done) state_next = HALT;
      end
      HALT: begin
        run_done = 1'b1;
        if (host_start) state_next = RELEASE;
      end
      default: state_next = LOAD;
    endcase
  end

  // Host port: read return, rejection pulse, and capture of DMEM writes.
  always_ff @(posedge clk) begin
    hw_addr <= host_addr;
    hw_data <= host_wdata[15:0];
    if (rst) begin
      host_rdata  <= '0;
      host_rvalid <= 1'b0;
      host_err    <= 1'b0;
      hw_pend     <= 1'b0;
    end else begin
      host_rvalid <= host_ok && host_re && !host_we;
      host_err    <= !host_ok && (host_we || host_re);
      hw_pend     <= host_ok && host_we && !host_sel;
      if (host_ok && host_re && !host_we)
        host_rdata <= host_sel ? imem[host_addr] : {2'b00, dmem[host_addr]};
    end
  end

  // Host writes into instruction memory.
  always_ff @(posedge clk) begin
    if (!rst && host_ok && host_we && host_sel)
      imem[host_addr] <= host_wdata;
  end

  // Run statistics: RUN cycle counter and CPU write counter, both saturating.
  always_ff @(posedge clk) begin
    if (rst || enter_release) begin
      cycle_count <= '0;
      wr_count    <= '0;
    end else begin
      if (state == RUN && cycle_count != '1)
        cycle_count <= cycle_count + 32'd1;
      if (cpu_wr && wr_count != '1)
        wr_count <= wr_count + 16'd1;
    end
  end

  // DMEM has a single write process: host writes captured on the rising
  // edge are committed on the following falling edge. Host and CPU writes
  // never collide because they are legal in disjoint states.
  always_ff @(negedge clk) begin
    if (hw_pend)
      dmem[hw_addr] <= hw_data;
    else if (cpu_write)
      dmem[data_address] <= data_out;
  end

  // CPU-facing port registers on the falling edge (half-cycle latency).
  always_ff @(negedge clk) begin
    if (rst) begin
      instruction_in <= '0;
      data_in        <= '0;
      cpu_wr         <= 1'b0;
    end else begin
      instruction_in <= imem[instruction_address];
      cpu_wr         <= cpu_write;
      if (cpu_read)
        data_in <= dmem[data_address];
    end
  end

endmodule

// File: tb/tb_simd_mem_responder.sv
// Self-checking bench for simd_mem_responder: table-driven host load and
// readback, then directed run, halt and reset-abort sequences.
module tb_simd_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        host_we, host_re, host_sel, host_start;
  logic [9:0]  host_addr;
  logic [17:0] host_wdata;
  logic [17:0] host_rdata;
  logic        host_rvalid, host_err, cpu_rst;
  logic [9:0]  instruction_address;
  logic [17:0] instruction_in;
  logic [9:0]  data_address;
  logic        data_R, data_W;
  logic [15:0] data_out, data_in;
  logic        done, run_done;
  logic [31:0] cycle_count;
  logic [15:0] wr_count;

  simd_mem_responder dut (
    .clk(clk), .rst(rst),
    .host_we(host_we), .host_re(host_re), .host_sel(host_sel),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_start(host_start),
    .host_rdata(host_rdata), .host_rvalid(host_rvalid), .host_err(host_err),
    .cpu_rst(cpu_rst),
    .instruction_address(instruction_address), .instruction_in(instruction_in),
    .data_address(data_address), .data_R(data_R), .data_W(data_W),
    .data_out(data_out), .data_in(data_in),
    .done(done), .run_done(run_done),
    .cycle_count(cycle_count), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sel;
    logic [9:0]  addr;
    logic [17:0] wdata;
    logic [17:0] rd;
  } vec_t;

  vec_t        vt [8];
  logic [17:0] exp_q [$];
  int          tests = 0;
  int          fails = 0;
  int          run_edges = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_tick();
    tick();
    run_edges++;
  endtask

  task automatic host_write(input logic sel, input logic [9:0] addr, input logic [17:0] wd);
    host_sel   = sel;
    host_addr  = addr;
    host_wdata = wd;
    host_we    = 1'b1;
    tick();
    host_we    = 1'b0;
  endtask

  task automatic host_read(input string name, input logic sel, input logic [9:0] addr,
                           input logic [17:0] exp);
    host_sel  = sel;
    host_addr = addr;
    host_re   = 1'b1;
    exp_q.push_back(exp);
    tick();
    host_re = 1'b0;
    chk({name, "_rvalid"}, {31'd0, host_rvalid}, 32'd1);
    if (exp_q.size() > 0)
      chk(name, {14'd0, host_rdata}, {14'd0, exp_q.pop_front()});
    tick();
    chk({name, "_rvalid_drop"}, {31'd0, host_rvalid}, 32'd0);
  endtask

  initial begin
    vt[0] = '{1'b0, 10'd0,    18'd5,       18'd5};
    vt[1] = '{1'b0, 10'd1,    18'd15,      18'd15};
    vt[2] = '{1'b0, 10'd2,    18'd4,       18'd4};
    vt[3] = '{1'b0, 10'd3,    18'h07777,   18'h07777};
    vt[4] = '{1'b0, 10'd7,    18'h01111,   18'h01111};
    vt[5] = '{1'b0, 10'd1023, 18'h3FFFF,   18'h0FFFF};
    vt[6] = '{1'b1, 10'd0,    18'h26000,   18'h26000};
    vt[7] = '{1'b1, 10'd5,    18'h3FFFF,   18'h3FFFF};

    rst = 1'b1; host_we = 1'b0; host_re = 1'b0; host_sel = 1'b0; host_start = 1'b0;
    host_addr = '0; host_wdata = '0; instruction_address = '0; data_address = '0;
    data_R = 1'b0; data_W = 1'b0; data_out = '0; done = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_cpu_rst",  {31'd0, cpu_rst},     32'd1);
    chk("rst_rvalid",   {31'd0, host_rvalid}, 32'd0);
    chk("rst_err",      {31'd0, host_err},    32'd0);
    chk("rst_run_done", {31'd0, run_done},    32'd0);
    chk("rst_rdata",    {14'd0, host_rdata},  32'd0);
    chk("rst_cycles",   cycle_count,          32'd0);
    chk("rst_wr",       {16'd0, wr_count},    32'd0);
    @(negedge clk); #1;
    chk("rst_instr",    {14'd0, instruction_in}, 32'd0);
    chk("rst_data_in",  {16'd0, data_in},        32'd0);
    rst = 1'b0;
    tick();

    // Table-driven host load and readback in LOAD
    for (int i = 0; i < 8; i++) host_write(vt[i].sel, vt[i].addr, vt[i].wdata);
    for (int i = 0; i < 8; i++) host_read($sformatf("load_rd%0d", i), vt[i].sel, vt[i].addr, vt[i].rd);

    // Simultaneous write and read: write wins, no read return
    host_sel = 1'b0; host_addr = 10'd4; host_wdata = 18'h01234;
    host_we = 1'b1; host_re = 1'b1;
    tick();
    host_we = 1'b0; host_re = 1'b0;
    chk("we_re_no_rvalid", {31'd0, host_rvalid}, 32'd0);
    host_read("we_re_data", 1'b0, 10'd4, 18'h01234);

    // Fetch works outside RUN
    instruction_address = 10'd5;
    @(negedge clk); #1;
    chk("fetch_load", {14'd0, instruction_in}, 32'h3FFFF);
    tick();

    // Start: two RELEASE cycles then RUN; host_start in RELEASE ignored
    host_start = 1'b1;
    tick();
    host_start = 1'b0;
    chk("release1_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    host_start = 1'b1;
    tick();
    host_start = 1'b0;
    chk("release2_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    tick();
    chk("run_cpu_rst", {31'd0, cpu_rst}, 32'd0);
    run_edges = 0;

    // Half-cycle fetch latency
    instruction_address = 10'd0;
    @(negedge clk); #1;
    chk("fetch_run", {14'd0, instruction_in}, 32'h26000);
    run_tick();

    // CPU write of DMEM[3]
    data_address = 10'd3; data_out = 16'h013A; data_R = 1'b1; data_W = 1'b1;
    run_tick();
    data_R = 1'b0; data_W = 1'b0;
    chk("wr_count_1", {16'd0, wr_count}, 32'd1);

    // CPU reads
    data_address = 10'd1; data_R = 1'b1; data_W = 1'b0;
    @(negedge clk); #1;
    chk("cpu_rd1", {16'd0, data_in}, 32'd15);
    run_tick();
    data_address = 10'd3;
    @(negedge clk); #1;
    chk("cpu_rd3", {16'd0, data_in}, 32'h013A);
    run_tick();

    // data_W without data_R: no access, data_in holds
    data_R = 1'b0; data_W = 1'b1; data_address = 10'd2; data_out = 16'hBEEF;
    @(negedge clk); #1;
    chk("w_only_hold", {16'd0, data_in}, 32'h013A);
    run_tick();
    data_W = 1'b0;
    chk("w_only_count", {16'd0, wr_count}, 32'd1);

    // Host access rejected in RUN
    host_sel = 1'b0; host_addr = 10'd0; host_wdata = 18'h00999; host_we = 1'b1;
    run_tick();
    host_we = 1'b0;
    chk("err_pulse", {31'd0, host_err}, 32'd1);
    run_tick();
    chk("err_clear", {31'd0, host_err}, 32'd0);

    // host_start in RUN ignored
    host_start = 1'b1;
    run_tick();
    host_start = 1'b0;
    chk("start_in_run", {31'd0, cpu_rst}, 32'd0);

    // Halt on the 89th RUN edge
    while (run_edges < 88) run_tick();
    done = 1'b1;
    run_tick();
    done = 1'b0;
    chk("halt_run_done", {31'd0, run_done}, 32'd1);
    chk("halt_cpu_rst",  {31'd0, cpu_rst},  32'd1);
    chk("halt_cycles",   cycle_count,       32'd89);

    // Readback in HALT
    host_read("halt_rd3", 1'b0, 10'd3, 18'h0013A);
    host_read("halt_rd0", 1'b0, 10'd0, 18'd5);
    host_read("halt_rd2", 1'b0, 10'd2, 18'd4);
    chk("halt_wr_count", {16'd0, wr_count}, 32'd1);

    // Restart clears counters
    host_start = 1'b1;
    tick();
    host_start = 1'b0;
    chk("restart_cycles", cycle_count,       32'd0);
    chk("restart_wr",     {16'd0, wr_count}, 32'd0);
    tick(); tick();
    chk("rerun_cpu_rst", {31'd0, cpu_rst}, 32'd0);

    // Reset mid-RUN
    data_address = 10'd6; data_out = 16'h00AA; data_R = 1'b1; data_W = 1'b1;
    tick();
    data_W = 1'b0;
    @(negedge clk); #1;
    chk("pre_rst_rd", {16'd0, data_in}, 32'h00AA);
    tick();
    rst = 1'b1; data_address = 10'd7; data_out = 16'h5555; data_W = 1'b1;
    @(negedge clk); #1;
    chk("abort_data_in", {16'd0, data_in}, 32'd0);
    @(posedge clk); #1;
    chk("abort_cpu_rst",  {31'd0, cpu_rst},  32'd1);
    chk("abort_run_done", {31'd0, run_done}, 32'd0);
    chk("abort_cycles",   cycle_count,       32'd0);
    chk("abort_wr",       {16'd0, wr_count}, 32'd0);
    rst = 1'b0; data_R = 1'b0; data_W = 1'b0;
    tick();
    host_read("abort_rd6", 1'b0, 10'd6, 18'h000AA);
    host_read("abort_rd7", 1'b0, 10'd7, 18'h01111);
    host_read("abort_rd0", 1'b0, 10'd0, 18'd5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
